// File: rtl/wb_data_stage.sv
// Writeback-select stage: picks the register-file write data, registers it with stall/flush,
// and traps illegal selects and misaligned halfword loads into a sticky flag and saturating count.
module wb_data_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_OFFSET = 8,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [2:0]            i_sel,
  input  logic                  i_unsigned,
  input  logic [1:0]            i_addr_lo,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0]     i_alu,
  input  logic [DATA_W-1:0]     i_mem,
  input  logic [15:0]           i_imm,
  input  logic [DATA_W-1:0]     i_pc,
  output logic                  o_valid,
  output logic                  o_we,
  output logic [REG_ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0]     o_wdata,
  output logic                  o_err,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("wb_data_stage: DATA_W must be 32");
  end

  localparam logic [2:0] SEL_ALU    = 3'd0;
  localparam logic [2:0] SEL_MEM_W  = 3'd1;
  localparam logic [2:0] SEL_MEM_B  = 3'd2;
  localparam logic [2:0] SEL_MEM_H  = 3'd3;
  localparam logic [2:0] SEL_IMM_UP = 3'd4;
  localparam logic [2:0] SEL_LINK   = 3'd5;

  logic [1:0]        byte_lane;
  logic [7:0]        mem_byte;
  logic              take_upper;
  logic [15:0]       mem_half;
  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] half_ext;
  logic [DATA_W-1:0] sel_data;
  logic              fault;
  logic              capture_we;

  // Big-endian lane 0 is the most significant byte, so the lane index is inverted.
  always_comb begin
    byte_lane  = BIG_ENDIAN ? ~i_addr_lo : i_addr_lo;
    mem_byte   = i_mem[{byte_lane, 3'b000} +: 8];
    take_upper = BIG_ENDIAN ? ~i_addr_lo[1] : i_addr_lo[1];
    mem_half   = take_upper ? i_mem[31:16] : i_mem[15:0];
    byte_ext   = {{(DATA_W-8){~i_unsigned & mem_byte[7]}}, mem_byte};
    half_ext   = {{(DATA_W-16){~i_unsigned & mem_half[15]}}, mem_half};
  end

  always_comb begin
    sel_data = '0;
    fault    = 1'b0;
    case (i_sel)
      SEL_ALU:    sel_data = i_alu;
      SEL_MEM_W:  sel_data = i_mem;
      SEL_MEM_B:  sel_data = byte_ext;
      SEL_MEM_H: begin
        sel_data = half_ext;
        fault    = i_addr_lo[0];
      end
      SEL_IMM_UP: sel_data = {i_imm, {(DATA_W-16){1'b0}}};
      SEL_LINK:   sel_data = i_pc + DATA_W'(LINK_OFFSET);
      default:    fault    = 1'b1;
    endcase
    capture_we = i_valid & i_we & (i_rd != '0) & ~fault;
  end

  // Stage control: no back-pressure output. i_flush (highest priority) kills valid/we and
  // records nothing; i_stall freezes every output; otherwise the inputs are captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid   <= 1'b0;
      o_we      <= 1'b0;
      o_waddr   <= '0;
      o_wdata   <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_we    <= 1'b0;
    end else if (!i_stall) begin
      o_valid <= i_valid;
      o_we    <= capture_we;
      o_waddr <= i_rd;
      o_wdata <= fault ? '0 : sel_data;
      if (i_valid && fault) begin
        o_err <= 1'b1;
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_data_stage.sv
// Directed bench for wb_data_stage: a big-endian and a little-endian instance share stimulus;
// a vector table covers the selects, hand sequences cover faults, stall, flush and reset.
module tb_wb_data_stage;

  logic        clock;
  logic        reset;
  logic        i_valid, i_stall, i_flush, i_unsigned, i_we;
  logic [2:0]  i_sel;
  logic [1:0]  i_addr_lo;
  logic [4:0]  i_rd;
  logic [31:0] i_alu, i_mem, i_pc;
  logic [15:0] i_imm;

  logic        be_valid, be_we, be_err;
  logic [4:0]  be_waddr;
  logic [31:0] be_wdata;
  logic [7:0]  be_err_cnt;
  logic        le_valid, le_we, le_err;
  logic [4:0]  le_waddr;
  logic [31:0] le_wdata;
  logic [7:0]  le_err_cnt;

  wb_data_stage #(.BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_sel(i_sel), .i_unsigned(i_unsigned), .i_addr_lo(i_addr_lo), .i_we(i_we), .i_rd(i_rd),
    .i_alu(i_alu), .i_mem(i_mem), .i_imm(i_imm), .i_pc(i_pc),
    .o_valid(be_valid), .o_we(be_we), .o_waddr(be_waddr), .o_wdata(be_wdata),
    .o_err(be_err), .o_err_cnt(be_err_cnt)
  );

  wb_data_stage #(.BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_sel(i_sel), .i_unsigned(i_unsigned), .i_addr_lo(i_addr_lo), .i_we(i_we), .i_rd(i_rd),
    .i_alu(i_alu), .i_mem(i_mem), .i_imm(i_imm), .i_pc(i_pc),
    .o_valid(le_valid), .o_we(le_we), .o_waddr(le_waddr), .o_wdata(le_wdata),
    .o_err(le_err), .o_err_cnt(le_err_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    logic        uns;
    logic [1:0]  addr_lo;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        exp_we;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] sel, input logic uns,
                       input logic [1:0] addr_lo, input logic we, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [15:0] imm, input logic [31:0] pc);
    i_valid = valid; i_sel = sel; i_unsigned = uns; i_addr_lo = addr_lo;
    i_we = we; i_rd = rd; i_alu = alu; i_mem = mem; i_imm = imm; i_pc = pc;
  endtask

  task automatic check_held(input string tag, input logic [31:0] exp_data, input logic [7:0] exp_cnt);
    check({tag, " valid"}, {31'd0, be_valid}, 32'd1);
    check({tag, " we"}, {31'd0, be_we}, 32'd1);
    check({tag, " waddr"}, {27'd0, be_waddr}, 32'd7);
    check({tag, " wdata"}, be_wdata, exp_data);
    check({tag, " cnt"}, {24'd0, be_err_cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234_5678, 32'h0, 16'h0, 32'h0, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{3'd1, 1'b0, 2'd0, 1'b1, 5'd4, 32'h0, 32'hDEAD_BEEF, 16'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2]  = '{3'd2, 1'b0, 2'd0, 1'b1, 5'd5, 32'h0, 32'h80FF_7F01, 16'h0, 32'h0, 1'b1, 32'hFFFF_FF80, 32'h0000_0001};
    vecs[3]  = '{3'd2, 1'b1, 2'd1, 1'b1, 5'd6, 32'h0, 32'h80FF_7F01, 16'h0, 32'h0, 1'b1, 32'h0000_00FF, 32'h0000_007F};
    vecs[4]  = '{3'd2, 1'b0, 2'd3, 1'b1, 5'd7, 32'h0, 32'h80FF_7F01, 16'h0, 32'h0, 1'b1, 32'h0000_0001, 32'hFFFF_FF80};
    vecs[5]  = '{3'd2, 1'b0, 2'd2, 1'b1, 5'd8, 32'h0, 32'h80FF_7F01, 16'h0, 32'h0, 1'b1, 32'h0000_007F, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd3, 1'b0, 2'd2, 1'b1, 5'd9, 32'h0, 32'h1234_8001, 16'h0, 32'h0, 1'b1, 32'hFFFF_8001, 32'h0000_1234};
    vecs[7]  = '{3'd3, 1'b1, 2'd0, 1'b1, 5'd10, 32'h0, 32'h1234_8001, 16'h0, 32'h0, 1'b1, 32'h0000_1234, 32'h0000_8001};
    vecs[8]  = '{3'd4, 1'b0, 2'd0, 1'b1, 5'd11, 32'h0, 32'h0, 16'hABCD, 32'h0, 1'b1, 32'hABCD_0000, 32'hABCD_0000};
    vecs[9]  = '{3'd5, 1'b0, 2'd0, 1'b1, 5'd31, 32'h0, 32'h0, 16'h0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004, 32'h0000_0004};
    vecs[10] = '{3'd0, 1'b0, 2'd0, 1'b1, 5'd0, 32'h5555_AAAA, 32'h0, 16'h0, 32'h0, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA};
    vecs[11] = '{3'd0, 1'b0, 2'd0, 1'b0, 5'd12, 32'h0BAD_F00D, 32'h0, 16'h0, 32'h0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D};

    reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 16'h0, 32'h0);
    cycle(); cycle();
    check("rst valid", {31'd0, be_valid}, 32'd0);
    check("rst we", {31'd0, be_we}, 32'd0);
    check("rst waddr", {27'd0, be_waddr}, 32'd0);
    check("rst wdata", be_wdata, 32'd0);
    check("rst err", {31'd0, be_err}, 32'd0);
    check("rst cnt", {24'd0, be_err_cnt}, 32'd0);
    reset = 1'b0;
    cycle();

    // table: one capture per cycle, back to back
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].uns, vecs[i].addr_lo, vecs[i].we, vecs[i].rd,
            vecs[i].alu, vecs[i].mem, vecs[i].imm, vecs[i].pc);
      exp_q.push_back(vecs[i].exp_be);
      cycle();
      check($sformatf("vec%0d valid", i), {31'd0, be_valid}, 32'd1);
      check($sformatf("vec%0d we", i), {31'd0, be_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d waddr", i), {27'd0, be_waddr}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d be_wdata", i), be_wdata, exp_q.pop_front());
      check($sformatf("vec%0d le_wdata", i), le_wdata, vecs[i].exp_le);
      check($sformatf("vec%0d err", i), {31'd0, be_err}, 32'd0);
    end

    // faults
    drive(1'b1, 3'd6, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1111_1111, 32'h0, 16'h0, 32'h0);
    cycle();
    check("illegal we", {31'd0, be_we}, 32'd0);
    check("illegal wdata", be_wdata, 32'd0);
    check("illegal err", {31'd0, be_err}, 32'd1);
    check("illegal cnt", {24'd0, be_err_cnt}, 32'd1);
    drive(1'b1, 3'd3, 1'b0, 2'd1, 1'b1, 5'd3, 32'h0, 32'h1234_8001, 16'h0, 32'h0);
    cycle();
    check("mis_h we", {31'd0, be_we}, 32'd0);
    check("mis_h cnt", {24'd0, be_err_cnt}, 32'd2);
    drive(1'b0, 3'd7, 1'b0, 2'd0, 1'b1, 5'd3, 32'h0, 32'h0, 16'h0, 32'h0);
    cycle();
    check("invalid fault valid", {31'd0, be_valid}, 32'd0);
    check("invalid fault cnt", {24'd0, be_err_cnt}, 32'd2);

    // stall: outputs frozen while inputs change
    drive(1'b1, 3'd0, 1'b0, 2'd0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h0, 16'h0, 32'h0);
    cycle();
    check_held("cap", 32'hCAFE_F00D, 8'd2);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 2'(i), 1'b1, 5'(i + 20),
            $urandom, $urandom, 16'(i), $urandom);
      cycle();
      check_held($sformatf("stall%0d", i), 32'hCAFE_F00D, 8'd2);
    end

    // flush beats stall, kills valid/we, records no fault
    i_flush = 1'b1;
    drive(1'b1, 3'd6, 1'b0, 2'd0, 1'b1, 5'd9, 32'h0, 32'h0, 16'h0, 32'h0);
    cycle();
    check("flush valid", {31'd0, be_valid}, 32'd0);
    check("flush we", {31'd0, be_we}, 32'd0);
    check("flush wdata hold", be_wdata, 32'hCAFE_F00D);
    check("flush waddr hold", {27'd0, be_waddr}, 32'd7);
    check("flush cnt", {24'd0, be_err_cnt}, 32'd2);
    i_flush = 1'b0; i_stall = 1'b0;

    // saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd7, 1'b0, 2'd0, 1'b1, 5'd1, 32'h0, 32'h0, 16'h0, 32'h0);
      cycle();
    end
    check("sat cnt", {24'd0, be_err_cnt}, 32'hFF);
    check("sat err", {31'd0, be_err}, 32'd1);

    // reset asserted mid-stall, between clock edges
    drive(1'b1, 3'd0, 1'b0, 2'd0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h0, 16'h0, 32'h0);
    cycle();
    check_held("pre_rst", 32'hCAFE_F00D, 8'hFF);
    i_stall = 1'b1;
    cycle();
    #2 reset = 1'b1;
    #1;
    check("async valid", {31'd0, be_valid}, 32'd0);
    check("async we", {31'd0, be_we}, 32'd0);
    check("async waddr", {27'd0, be_waddr}, 32'd0);
    check("async wdata", be_wdata, 32'd0);
    check("async err", {31'd0, be_err}, 32'd0);
    check("async cnt", {24'd0, be_err_cnt}, 32'd0);
    check("async le cnt", {24'd0, le_err_cnt}, 32'd0);
    cycle();
    reset = 1'b0; i_stall = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
